// File: rtl/gpio_stim_pkg.sv
// -----------------------------------------------------------------------------
// gpio_stim_pkg
// Shared definitions for the GPIO stimulus generator:
//   - default values for the gpio_stim_gen parameters
//   - the sequencer state enumeration
//   - a small helper that sizes the phase counter
// Build option: GPIO_STIM_FIFO_EN (see gpio_stim_gen) chooses between the
// command FIFO and a single holding register. Nothing in this package
// depends on it.
// -----------------------------------------------------------------------------
package gpio_stim_pkg;

    localparam int GPIO_W_DEF  = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int T_SETUP_DEF = 2;
    localparam int T_HIGH_DEF  = 5;
    localparam int T_LOW_DEF   = 5;

    // One command walks through every timed state in this order, then
    // returns to IDLE or chains directly into the next command.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP1 = 3'd1,
        SETUP2 = 3'd2,
        HIGH1  = 3'd3,
        HIGH2  = 3'd4,
        LOW    = 3'd5
    } state_t;

    // Largest of the three phase lengths. The phase counter must be able
    // to reach this value minus one.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/gpio_stim_fifo.sv
// -----------------------------------------------------------------------------
// gpio_stim_fifo
// Show-ahead command FIFO for gpio_stim_gen. The head entry is visible on
// rd_data whenever rd_valid is high, and it is consumed on the edge where
// rd_en is high.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset, empties the FIFO
//   wr_valid  : write request. An entry is written when wr_valid && wr_ready
//   wr_ready  : registered "not full". It is 0 in reset and 1 from the first
//               edge after release
//   wr_data   : write data, W bits
//   rd_en     : consume the head entry. It is ignored when empty
//   rd_valid  : FIFO holds at least one entry
//   rd_data   : head entry, W bits
//
// Parameters
//   W     : entry width
//   DEPTH : number of entries, power of two, 2..16
// -----------------------------------------------------------------------------
module gpio_stim_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          ready_reg;
    logic          push;
    logic          pop;

    assign push = wr_valid && ready_reg;
    assign pop  = rd_en && (count_reg != '0);

    // The occupancy counter has one more bit than the pointers, so "full"
    // and "empty" stay distinct after the pointers wrap.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their
    // own. Ready looks only at the next occupancy. A pop in the same cycle
    // therefore cannot make a full FIFO look ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_CNT);
        end
    end

    // Storage is not reset. An entry is only read after it has been
    // written, because the occupancy counter is cleared on reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // The sequencer acts on the head entry in the same cycle that it pops
    // it, so the array is read combinationally. This is a small LUT RAM.
    assign rd_data  = mem[rd_ptr_reg];
    assign rd_valid = (count_reg != '0);
    assign wr_ready = ready_reg;

endmodule

// File: rtl/gpio_stim_gen.sv
// -----------------------------------------------------------------------------
// gpio_stim_gen
// Drives a gpio bus and a generated external strobe (ext_clk) from a stream
// of commands. Each command gives target gpio values and, per bit, the moment
// the bit changes:
//   use_ext=0          : update on the pop edge
//   use_ext=1, edge=1  : update at the end of SETUP1, before ext_clk rises
//   use_ext=1, edge=0  : update at the end of HIGH1, before ext_clk falls
// Waveform of one command (P = pop edge):
//   SETUP1 (T_SETUP) -> SETUP2 (T_SETUP) -> ext_clk=1 -> HIGH1 (T_HIGH)
//   -> HIGH2 (T_HIGH) -> ext_clk=0 -> LOW (T_LOW) -> done pulse.
// The next command pops on the done edge when one is waiting.
//
// Build option
//   GPIO_STIM_FIFO_EN defined   : DEPTH-entry command FIFO (gpio_stim_fifo)
//   GPIO_STIM_FIFO_EN undefined : single holding register, DEPTH is ignored
//
// Ports
//   clk         : sole clock
//   rst_n       : asynchronous active-low reset
//   cmd_valid   : command offered
//   cmd_ready   : command can be accepted. Registered, and depends only on
//                 how full the command store is
//   cmd_gpio    : target gpio values
//   cmd_use_ext : per bit, 1 = update timed to ext_clk
//   cmd_edge    : per ext bit, 1 = before ext_clk rise, 0 = before fall
//   gpio        : driven gpio bus
//   ext_clk     : generated strobe
//   busy        : sequencer active or a command is waiting
//   done        : one-cycle pulse at the end of each command
// -----------------------------------------------------------------------------
module gpio_stim_gen
    import gpio_stim_pkg::*;
#(
    parameter int GPIO_W  = GPIO_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_HIGH  = T_HIGH_DEF,
    parameter int T_LOW   = T_LOW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [GPIO_W-1:0] cmd_gpio,
    input  logic [GPIO_W-1:0] cmd_use_ext,
    input  logic [GPIO_W-1:0] cmd_edge,
    output logic [GPIO_W-1:0] gpio,
    output logic              ext_clk,
    output logic              busy,
    output logic              done
);

    localparam int CMD_W = 3 * GPIO_W;
    localparam int T_MAX = max3(T_SETUP, T_HIGH, T_LOW);
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] TC_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] TC_HIGH  = CNT_W'(T_HIGH - 1);
    localparam logic [CNT_W-1:0] TC_LOW   = CNT_W'(T_LOW - 1);

    // ------------------------------------------------------------------
    // Command store: the head is visible on src_data while src_valid is high
    // ------------------------------------------------------------------
    logic             src_valid;
    logic [CMD_W-1:0] src_data;
    logic             pop;

`ifdef GPIO_STIM_FIFO_EN
    gpio_stim_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (cmd_valid),
        .wr_ready (cmd_ready),
        .wr_data  ({cmd_edge, cmd_use_ext, cmd_gpio}),
        .rd_en    (pop),
        .rd_valid (src_valid),
        .rd_data  (src_data)
    );
`else
    logic             hold_valid_reg;
    logic             hold_valid_next;
    logic             hold_ready_reg;
    logic [CMD_W-1:0] hold_data_reg;
    logic             hold_push;
    logic             unused_depth;

    // DEPTH has no meaning with a single holding register.
    assign unused_depth = ^DEPTH;

    // Ready is only high while the register is empty, so a push and a pop
    // never happen in the same cycle.
    assign hold_push = cmd_valid && hold_ready_reg;

    always_comb begin
        hold_valid_next = hold_valid_reg;
        if (hold_push) begin
            hold_valid_next = 1'b1;
        end else if (pop) begin
            hold_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_reg <= 1'b0;
            hold_ready_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else begin
            hold_valid_reg <= hold_valid_next;
            hold_ready_reg <= !hold_valid_next;
            if (hold_push) begin
                hold_data_reg <= {cmd_edge, cmd_use_ext, cmd_gpio};
            end
        end
    end

    assign src_valid = hold_valid_reg;
    assign src_data  = hold_data_reg;
    assign cmd_ready = hold_ready_reg;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             phase_done;

    logic [CMD_W-1:0]  cur_reg;
    logic [GPIO_W-1:0] gpio_reg;
    logic [GPIO_W-1:0] gpio_next;
    logic              ext_clk_reg;
    logic              ext_clk_next;
    logic              done_reg;
    logic              done_next;

    logic [GPIO_W-1:0] head_gpio;
    logic [GPIO_W-1:0] head_use;
    logic [GPIO_W-1:0] cur_gpio;
    logic [GPIO_W-1:0] cur_use;
    logic [GPIO_W-1:0] cur_edge;
    logic [GPIO_W-1:0] mask_start;
    logic [GPIO_W-1:0] mask_rise;
    logic [GPIO_W-1:0] mask_fall;
    logic [GPIO_W-1:0] upd_mask;
    logic [GPIO_W-1:0] upd_src;
    logic              upd_from_head;

    assign head_gpio = src_data[GPIO_W-1:0];
    assign head_use  = src_data[2*GPIO_W-1:GPIO_W];
    assign cur_gpio  = cur_reg[GPIO_W-1:0];
    assign cur_use   = cur_reg[2*GPIO_W-1:GPIO_W];
    assign cur_edge  = cur_reg[3*GPIO_W-1:2*GPIO_W];

    // The last cycle of each timed state. The state exits on this edge.
    always_comb begin
        phase_done = 1'b0;
        case (state_reg)
            SETUP1, SETUP2: phase_done = (cnt_reg == TC_SETUP);
            HIGH1, HIGH2:   phase_done = (cnt_reg == TC_HIGH);
            LOW:            phase_done = (cnt_reg == TC_LOW);
            default:        phase_done = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. LOW goes straight to SETUP1 when a command is
    // waiting, so commands chain without an idle cycle between them.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (src_valid)  state_next = SETUP1;
            SETUP1:  if (phase_done) state_next = SETUP2;
            SETUP2:  if (phase_done) state_next = HIGH1;
            HIGH1:   if (phase_done) state_next = HIGH2;
            HIGH2:   if (phase_done) state_next = LOW;
            LOW:     if (phase_done) state_next = src_valid ? SETUP1 : IDLE;
            default: state_next = IDLE;
        endcase

        // Each timed state starts counting from zero.
        if (state_reg == IDLE || phase_done) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Output logic: pop request, which gpio bits to update, strobe and done.
    always_comb begin
        pop           = 1'b0;
        upd_mask      = '0;
        upd_from_head = 1'b0;
        ext_clk_next  = ext_clk_reg;
        done_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (src_valid) begin
                    pop           = 1'b1;
                    upd_mask      = mask_start;
                    upd_from_head = 1'b1;
                end
            end
            SETUP1: if (phase_done) upd_mask     = mask_rise;
            SETUP2: if (phase_done) ext_clk_next = 1'b1;
            HIGH1:  if (phase_done) upd_mask     = mask_fall;
            HIGH2:  if (phase_done) ext_clk_next = 1'b0;
            LOW: begin
                if (phase_done) begin
                    done_next = 1'b1;
                    if (src_valid) begin
                        pop           = 1'b1;
                        upd_mask      = mask_start;
                        upd_from_head = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bits taken from the command that is popping take their values from the
    // head entry. Later updates take them from the latched current command.
    assign upd_src = upd_from_head ? head_gpio : cur_gpio;

    // Per-bit masks and update mux. A bit that is not selected keeps its value.
    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_bit
        assign mask_start[gi] = ~head_use[gi];
        assign mask_rise[gi]  = cur_use[gi] & cur_edge[gi];
        assign mask_fall[gi]  = cur_use[gi] & ~cur_edge[gi];
        assign gpio_next[gi]  = upd_mask[gi] ? upd_src[gi] : gpio_reg[gi];
    end

    // Registered outputs and the current command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_reg    <= '0;
            ext_clk_reg <= 1'b0;
            done_reg    <= 1'b0;
            cur_reg     <= '0;
        end else begin
            gpio_reg    <= gpio_next;
            ext_clk_reg <= ext_clk_next;
            done_reg    <= done_next;
            if (pop) begin
                cur_reg <= src_data;
            end
        end
    end

    assign gpio    = gpio_reg;
    assign ext_clk = ext_clk_reg;
    assign done    = done_reg;
    assign busy    = (state_reg != IDLE) || src_valid;

endmodule
